// File: rtl/bt_buf_seq_pkg.sv
// ============================================================================
// Module   : bt_buf_seq_pkg
// Desc     : Shared constants for the Bt input-B buffer sequencer: state
//            encoding, default buffer geometry and the buffer data width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bt_buf_seq_pkg;

    // Default buffer geometry (DEPTH must equal 2**ADDR_W)
    localparam int c_DEPTH_DEF      = 16;
    localparam int c_ADDR_W_DEF     = 4;
    localparam int c_PASS_W_DEF     = 4;

    // Width of one Bt buffer entry; data never flows through the sequencer
    localparam int c_BT_BU_DA_WIDTH = 512;

    // Sequencer state encoding
    localparam int              c_ST_W     = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_FILL  = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_PRIME = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_DRAIN = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/bt_seq_cnt.sv
// ============================================================================
// Module   : bt_seq_cnt
// Desc     : Modulo-len up counter with clear, enable and terminal-count
//            flag. o_tc is high while the count equals len-1; an enabled
//            step from that value returns the count to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bt_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W:0]   i_len,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W:0]   c_LEN_ONE = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] c_CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;
    logic [W:0]   w_last;

    // Terminal value is len-1; len is one bit wider so len==2**W is legal
    assign w_last = i_len - c_LEN_ONE;
    assign o_tc   = ({1'b0, r_cnt} == w_last);
    assign o_cnt  = r_cnt;

    // Count register: clear wins over enable, wrap to zero at terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : (r_cnt + c_CNT_ONE);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bt_buf_seq.sv
// ============================================================================
// Module   : bt_buf_seq
// Desc     : Control sequencer for the Bt input-B buffer. Loads len entries
//            from a valid/ready source, then drains the buffer np times to
//            the consumer, aligning out_valid/out_last with the buffer's
//            one-cycle registered read data.
// Optional : BT_BUF_SEQ_PERF_EN adds perf_fill_stall / perf_drain_stall
//            saturating stall counters (cleared on start).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bt_buf_seq
    import bt_buf_seq_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int PASS_W = c_PASS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ks_in,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [PASS_W-1:0] num_pass,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] a_Bt,
    output logic              we_Bt,
    output logic              kernelsize_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
`ifdef BT_BUF_SEQ_PERF_EN
    output logic [15:0]       perf_fill_stall,
    output logic [15:0]       perf_drain_stall,
`else
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   c_LEN_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] c_NP_ONE   = {{(PASS_W-1){1'b0}}, 1'b1};

    logic [c_ST_W-1:0] r_state;
    logic              r_ks;
    logic [ADDR_W:0]   r_len;
    logic [PASS_W-1:0] r_np;

    logic [ADDR_W:0]   w_len_norm;
    logic [PASS_W-1:0] w_np_norm;
    logic              w_start_acc;
    logic              w_fire;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_ptr_tc;
    logic              w_ptr_en;
    logic              w_ptr_clr;
    logic [PASS_W-1:0] w_pass_cnt;
    logic              w_pass_tc;
    logic              w_pass_en;
    logic              w_more_pass;

    // Zero or oversize fill length means a full buffer; zero passes means one
    assign w_len_norm  = ((fill_len == '0) || (fill_len > c_LEN_MAX)) ? c_LEN_MAX : fill_len;
    assign w_np_norm   = (num_pass == '0) ? c_NP_ONE : num_pass;
    assign w_start_acc = start & (r_state == c_ST_IDLE);

    // Control outputs decoded from the state register
    assign in_ready      = (r_state == c_ST_FILL);
    assign we_Bt         = in_valid & in_ready;
    assign out_valid     = (r_state == c_ST_DRAIN);
    assign w_fire        = out_valid & out_ready;
    assign out_last      = out_valid & w_ptr_tc & w_pass_tc;
    assign busy          = (r_state != c_ST_IDLE);
    assign done          = (r_state == c_ST_DONE);
    assign kernelsize_op = r_ks;

    // One pointer serves as wr_ptr in FILL and rd_ptr in DRAIN
    assign w_ptr_en    = we_Bt | w_fire;
    assign w_ptr_clr   = w_start_acc | (r_state == c_ST_PRIME);
    assign w_pass_en   = w_fire & w_ptr_tc;
    assign w_more_pass = (w_pass_cnt < (r_np - c_NP_ONE));

    bt_seq_cnt #(
        .W (ADDR_W)
    ) u_ptr_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_ptr_clr),
        .i_en  (w_ptr_en),
        .i_len (r_len),
        .o_cnt (w_ptr),
        .o_tc  (w_ptr_tc)
    );

    bt_seq_cnt #(
        .W (PASS_W)
    ) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start_acc),
        .i_en  (w_pass_en),
        .i_len ({1'b0, r_np}),
        .o_cnt (w_pass_cnt),
        .o_tc  (w_pass_tc)
    );

    // Buffer address: look ahead by one entry on a drain handshake so the
    // registered read already holds the next entry; hold it on a stall
    always_comb begin
        a_Bt = '0;
        case (r_state)
            c_ST_FILL:  a_Bt = w_ptr;
            c_ST_DRAIN: begin
                if (w_fire) begin
                    a_Bt = w_ptr_tc ? '0 : (w_ptr + c_ADDR_ONE);
                end else begin
                    a_Bt = w_ptr;
                end
            end
            default:    a_Bt = '0;
        endcase
    end

    // Sequencer FSM and job parameters latched on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ks    <= 1'b0;
            r_len   <= '0;
            r_np    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_ks    <= ks_in;
                        r_len   <= w_len_norm;
                        r_np    <= w_np_norm;
                        r_state <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (we_Bt && w_ptr_tc) begin
                        r_state <= c_ST_PRIME;
                    end
                end
                c_ST_PRIME: begin
                    r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    if (w_fire && w_ptr_tc && !w_more_pass) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef BT_BUF_SEQ_PERF_EN
    logic [15:0] r_perf_fill;
    logic [15:0] r_perf_drain;

    assign perf_fill_stall  = r_perf_fill;
    assign perf_drain_stall = r_perf_drain;

    // Saturating stall counters, cleared when a new job starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fill  <= '0;
            r_perf_drain <= '0;
        end else if (w_start_acc) begin
            r_perf_fill  <= '0;
            r_perf_drain <= '0;
        end else begin
            if (in_ready && !in_valid && (r_perf_fill != 16'hFFFF)) begin
                r_perf_fill <= r_perf_fill + 16'd1;
            end
            if (out_valid && !out_ready && (r_perf_drain != 16'hFFFF)) begin
                r_perf_drain <= r_perf_drain + 16'd1;
            end
        end
    end
`else
    // Stall counters are not built in this configuration
`endif

endmodule

`default_nettype wire
